bullet_pool: RTL and testbench

- Parametrised successor to the single-port bullet store. Holds up to DEPTH bullet records with a per-slot valid bit, a live count and a free-slot allocator.
- Adds a random-access read port and a sequential scan port that walks only occupied slots.
- Sits between game logic, which spawns, updates and kills bullets, and the renderer/collision engine, which scans all live bullets each frame.

---
 rtl/bullet_pool.sv | 149 ++++++++++++++
 tb/tb_bullet_pool.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_pool.sv
// Bullet record pool: DEPTH slots with per-slot valid bits, lowest-free allocator,
// 1-cycle random read port and a scanner that reports only occupied slots.
module bullet_pool #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 6,
   parameter int DEPTH         = 64
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     alloc_req,
   input  logic [DATA_WIDTH-1:0]    alloc_data,
   output logic                     alloc_ack,
   output logic                     alloc_fail,
   output logic [ADDRESS_WIDTH-1:0] alloc_addr,
   output logic                     full,
   output logic [ADDRESS_WIDTH:0]   count,
   input  logic                     wEn,
   input  logic [ADDRESS_WIDTH-1:0] wAddr,
   input  logic [DATA_WIDTH-1:0]    dataIn,
   input  logic                     free_req,
   input  logic [ADDRESS_WIDTH-1:0] free_addr,
   input  logic                     readEn,
   input  logic [ADDRESS_WIDTH-1:0] rAddr,
   output logic [DATA_WIDTH-1:0]    dataOut,
   output logic                     rValid,
   input  logic                     scan_start,
   output logic                     scan_busy,
   output logic                     scan_valid,
   output logic [ADDRESS_WIDTH-1:0] scan_addr,
   output logic [DATA_WIDTH-1:0]    scan_data,
   output logic                     scan_done
);
   localparam int CW = ADDRESS_WIDTH + 1;

   typedef enum logic {IDLE, RUN} scan_state_t;

   logic [DATA_WIDTH-1:0]    mem [DEPTH];
   logic [DEPTH-1:0]         valid;
   logic [DEPTH-1:0]         valid_nxt;
   logic [ADDRESS_WIDTH-1:0] cand;
   logic                     do_alloc;
   logic                     do_free;
   logic                     do_upd;

   scan_state_t              state, state_nxt;
   logic [ADDRESS_WIDTH-1:0] idx, idx_nxt;
   logic                     last;
   logic                     report;

   always_comb begin
      cand = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!valid[i]) cand = ADDRESS_WIDTH'(i);
   end

   assign full     = &valid;
   assign do_alloc = alloc_req & ~full;
   assign do_free  = free_req & valid[free_addr];
   // A kill on the same slot as an update drops the update.
   assign do_upd   = wEn & valid[wAddr] & ~(free_req && (free_addr == wAddr));

   always_comb begin
      valid_nxt = valid;
      if (do_alloc) valid_nxt[cand] = 1'b1;
      if (do_free)  valid_nxt[free_addr] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= '0;
         count <= '0;
      end else begin
         valid <= valid_nxt;
         count <= count + CW'(do_alloc) - CW'(do_free);
      end
   end

   // The alloc candidate is always an invalid slot, so it never collides with an update.
   always_ff @(posedge clk) begin
      if (do_alloc) mem[cand]  <= alloc_data;
      if (do_upd)   mem[wAddr] <= dataIn;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alloc_ack  <= 1'b0;
         alloc_fail <= 1'b0;
         alloc_addr <= '0;
         dataOut    <= '0;
         rValid     <= 1'b0;
      end else begin
         alloc_ack  <= do_alloc;
         alloc_fail <= alloc_req & full;
         if (do_alloc) alloc_addr <= cand;
         if (readEn) begin
            dataOut <= mem[rAddr];
            rValid  <= valid[rAddr];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      case (state)
         IDLE: if (scan_start) begin
            state_nxt = RUN;
            idx_nxt   = '0;
         end
         RUN: begin
            idx_nxt = idx + ADDRESS_WIDTH'(1);
            if (last) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      scan_busy = (state == RUN);
      last      = (state == RUN) && (idx == ADDRESS_WIDTH'(DEPTH - 1));
      report    = (state == RUN) && valid[idx];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         scan_valid <= 1'b0;
         scan_done  <= 1'b0;
         scan_addr  <= '0;
         scan_data  <= '0;
      end else begin
         scan_valid <= report;
         scan_done  <= last;
         if (report) begin
            scan_addr <= idx;
            scan_data <= mem[idx];
         end
      end
   end
endmodule

// File: tb/tb_bullet_pool.sv
// Directed + randomized bench for bullet_pool, checked every cycle against a slot-array model.
module tb_bullet_pool;
   localparam int DW = 32;
   localparam int AW = 6;
   localparam int D  = 64;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic          alloc_req = 1'b0;
   logic [DW-1:0] alloc_data = '0;
   logic          alloc_ack, alloc_fail, full;
   logic [AW-1:0] alloc_addr;
   logic [AW:0]   count;
   logic          wEn = 1'b0;
   logic [AW-1:0] wAddr = '0;
   logic [DW-1:0] dataIn = '0;
   logic          free_req = 1'b0;
   logic [AW-1:0] free_addr = '0;
   logic          readEn = 1'b0;
   logic [AW-1:0] rAddr = '0;
   logic [DW-1:0] dataOut;
   logic          rValid;
   logic          scan_start = 1'b0;
   logic          scan_busy, scan_valid, scan_done;
   logic [AW-1:0] scan_addr;
   logic [DW-1:0] scan_data;

   bullet_pool #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(D)) dut (
      .clk(clk), .reset_n(reset_n),
      .alloc_req(alloc_req), .alloc_data(alloc_data), .alloc_ack(alloc_ack),
      .alloc_fail(alloc_fail), .alloc_addr(alloc_addr), .full(full), .count(count),
      .wEn(wEn), .wAddr(wAddr), .dataIn(dataIn),
      .free_req(free_req), .free_addr(free_addr),
      .readEn(readEn), .rAddr(rAddr), .dataOut(dataOut), .rValid(rValid),
      .scan_start(scan_start), .scan_busy(scan_busy), .scan_valid(scan_valid),
      .scan_addr(scan_addr), .scan_data(scan_data), .scan_done(scan_done)
   );

   always #5 clk = ~clk;

   // Reference model: slot contents, occupancy and scan progress as plain arrays/ints.
   bit            m_valid [D];
   logic [DW-1:0] m_mem   [D];
   bit            m_wr    [D];
   bit            m_busy;
   int            m_idx;

   bit            e_ack, e_fail, e_rv, e_sv, e_sdone, e_dout_known;
   logic [AW-1:0] e_aaddr, e_saddr;
   logic [DW-1:0] e_dout, e_sdata;

   int checks = 0;
   int errors = 0;

   int rep_q[$];
   int busy_cycles;
   int done_seen;
   bit done_with_63;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int popcount();
      int n = 0;
      foreach (m_valid[i]) n += m_valid[i];
      return n;
   endfunction

   task automatic idle();
      alloc_req  = 1'b0;
      wEn        = 1'b0;
      free_req   = 1'b0;
      readEn     = 1'b0;
      scan_start = 1'b0;
   endtask

   task automatic clear_log();
      rep_q.delete();
      busy_cycles  = 0;
      done_seen    = 0;
      done_with_63 = 1'b0;
   endtask

   task automatic check_all();
      int pc = popcount();
      chk("alloc_ack", alloc_ack, e_ack);
      chk("alloc_fail", alloc_fail, e_fail);
      if (e_ack) chk("alloc_addr", alloc_addr, e_aaddr);
      chk("full", full, pc == D);
      chk("count", count, pc);
      chk("rValid", rValid, e_rv);
      if (e_dout_known) chk("dataOut", dataOut, e_dout);
      chk("scan_busy", scan_busy, m_busy);
      chk("scan_valid", scan_valid, e_sv);
      chk("scan_done", scan_done, e_sdone);
      if (e_sv) begin
         chk("scan_addr", scan_addr, e_saddr);
         chk("scan_data", scan_data, e_sdata);
      end
   endtask

   // Predict from pre-edge model state, clock once, then compare.
   task automatic step();
      int cand = -1;
      bit free_eff;
      for (int i = 0; i < D; i++)
         if (!m_valid[i]) begin
            cand = i;
            break;
         end
      e_ack  = alloc_req && (cand >= 0);
      e_fail = alloc_req && (cand < 0);
      if (e_ack) e_aaddr = AW'(cand);
      if (readEn) begin
         e_dout       = m_mem[rAddr];
         e_dout_known = m_wr[rAddr];
         e_rv         = m_valid[rAddr];
      end
      e_sv    = 1'b0;
      e_sdone = 1'b0;
      if (m_busy) begin
         if (m_valid[m_idx]) begin
            e_sv    = 1'b1;
            e_saddr = AW'(m_idx);
            e_sdata = m_mem[m_idx];
         end
         if (m_idx == D - 1) begin
            e_sdone = 1'b1;
            m_busy  = 1'b0;
         end else begin
            m_idx++;
         end
      end else if (scan_start) begin
         m_busy = 1'b1;
         m_idx  = 0;
      end
      free_eff = free_req && m_valid[free_addr];
      if (wEn && m_valid[wAddr] && !(free_req && free_addr == wAddr)) m_mem[wAddr] = dataIn;
      if (e_ack) begin
         m_mem[cand]   = alloc_data;
         m_wr[cand]    = 1'b1;
         m_valid[cand] = 1'b1;
      end
      if (free_eff) m_valid[free_addr] = 1'b0;
      @(posedge clk);
      #1;
      check_all();
      if (scan_valid) rep_q.push_back(int'(scan_addr));
      if (scan_busy) busy_cycles++;
      if (scan_done) begin
         done_seen++;
         done_with_63 = scan_valid && (scan_addr == AW'(D - 1));
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_busy = 1'b0;
      m_idx  = 0;
      e_ack = 1'b0; e_fail = 1'b0; e_rv = 1'b0; e_sv = 1'b0; e_sdone = 1'b0;
      e_dout = '0; e_dout_known = 1'b1;
      check_all();
      chk("rst_dataOut", dataOut, 0);
      chk("rst_alloc_addr", alloc_addr, 0);
      chk("rst_scan_addr", scan_addr, 0);
      chk("rst_scan_data", scan_data, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      bit found40;
      int guard;
      idle();
      foreach (m_wr[i]) m_wr[i] = 1'b0;
      #2;
      do_reset();

      for (int k = 0; k < 3; k++) begin
         idle(); alloc_req = 1'b1; alloc_data = 32'hA0 + k; step();
         chk("first_alloc_addr", alloc_addr, k);
      end
      idle(); readEn = 1'b1; rAddr = 6'd1; step();
      chk("count3", count, 3);
      chk("rd1_valid", rValid, 1);
      chk("rd1_data", dataOut, 32'hA1);

      for (int k = 3; k < 6; k++) begin
         idle(); alloc_req = 1'b1; alloc_data = 32'hC0 + k; step();
      end
      idle(); free_req = 1'b1; free_addr = 6'd1; step();
      idle(); alloc_req = 1'b1; alloc_data = 32'hB0; step();
      chk("realloc_addr", alloc_addr, 1);
      idle(); free_req = 1'b1; free_addr = 6'd5; step();
      idle(); wEn = 1'b1; wAddr = 6'd5; dataIn = 32'hFF; step();
      idle(); readEn = 1'b1; rAddr = 6'd5; step();
      chk("rd5_valid", rValid, 0);
      chk("rd5_data_kept", dataOut, 32'hC5);

      idle(); alloc_req = 1'b1; guard = 0;
      while (popcount() < D && guard < 100) begin
         alloc_data = $urandom; step(); guard++;
      end
      chk("fill_full", full, 1);
      chk("fill_count", count, 64);
      step();
      chk("over_fail", alloc_fail, 1);
      chk("over_ack", alloc_ack, 0);
      free_req = 1'b1; free_addr = 6'd63; step();
      chk("free_alloc_fail", alloc_fail, 1);
      chk("free_alloc_count", count, 63);

      idle(); alloc_req = 1'b1; alloc_data = 32'h6363_0063; step();
      chk("alloc63", alloc_addr, 63);
      for (int s = 1; s < 63; s++) begin
         if (s != 7) begin
            idle(); free_req = 1'b1; free_addr = AW'(s); step();
         end
      end
      clear_log();
      idle(); scan_start = 1'b1; step();
      idle(); guard = 0;
      while (done_seen == 0 && guard < 100) begin step(); guard++; end
      chk("scan_busy_cycles", busy_cycles, 64);
      chk("scan_nreports", rep_q.size(), 3);
      if (rep_q.size() == 3) begin
         chk("scan_rep0", rep_q[0], 0);
         chk("scan_rep1", rep_q[1], 7);
         chk("scan_rep2", rep_q[2], 63);
      end
      chk("scan_done_with_63", done_with_63, 1);

      idle(); alloc_req = 1'b1; guard = 0;
      while (!m_valid[40] && guard < 70) begin alloc_data = $urandom; step(); guard++; end
      clear_log();
      idle(); scan_start = 1'b1; step();
      guard = 0;
      while (done_seen == 0 && guard < 100) begin
         idle();
         if (m_idx == 20) begin free_req = 1'b1; free_addr = 6'd40; end
         if (m_idx == 25) scan_start = 1'b1;
         step(); guard++;
      end
      idle(); step(); step();
      found40 = 1'b0;
      foreach (rep_q[i]) if (rep_q[i] == 40) found40 = 1'b1;
      chk("freed40_not_reported", found40, 0);
      chk("restart_ignored_done", done_seen, 1);
      chk("restart_ignored_busy", busy_cycles, 64);

      for (int n = 0; n < 400; n++) begin
         alloc_req  = ($urandom_range(0, 2) != 0);
         alloc_data = $urandom;
         free_req   = ($urandom_range(0, 1) != 0);
         free_addr  = AW'($urandom_range(0, D - 1));
         wEn        = ($urandom_range(0, 1) != 0);
         wAddr      = ($urandom_range(0, 3) == 0) ? free_addr : AW'($urandom_range(0, D - 1));
         dataIn     = $urandom;
         readEn     = ($urandom_range(0, 1) != 0);
         rAddr      = AW'($urandom_range(0, D - 1));
         scan_start = ($urandom_range(0, 15) == 0);
         step();
      end

      idle(); step(); guard = 0;
      while (m_busy && guard < 100) begin step(); guard++; end
      scan_start = 1'b1; step();
      idle(); guard = 0;
      while (m_idx != 30 && guard < 100) begin step(); guard++; end
      clear_log();
      do_reset();
      chk("rst_mid_scan_busy", scan_busy, 0);
      chk("rst_mid_scan_count", count, 0);
      idle();
      for (int n = 0; n < 40; n++) step();
      chk("rst_mid_scan_no_done", done_seen, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
